// File: rtl/ntt_memory_sequencer.sv
// Memory-side sequencer for the streaming NTT/INTT core: streams a polynomial out of
// BRAM, writes core results back (optionally bit-reversed) and pulses done per run.
module ntt_memory_sequencer #(
  parameter int LOGN        = 12,
  parameter int LOGQ        = 64,
  parameter int LOG_LANES   = 1,
  parameter int START_DELAY = 10,
  parameter int ADDR_W      = 11,
  parameter int BITREV_WR   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        intt,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  input  logic [(LOGQ<<LOG_LANES)-1:0] bram_dout,
  output logic [(LOGQ<<LOG_LANES)-1:0] bram_din,
  output logic                        core_start,
  output logic                        core_intt,
  output logic [(LOGQ<<LOG_LANES)-1:0] core_in,
  input  logic [(LOGQ<<LOG_LANES)-1:0] core_out,
  input  logic                        core_out_valid
);

  localparam int WL    = LOGN - LOG_LANES;
  localparam int WORDS = 1 << WL;

  localparam logic [WL:0] LAST_WORD  = (WL+1)'(WORDS - 1);
  localparam logic [WL:0] ALL_WORDS  = (WL+1)'(WORDS);
  localparam logic [7:0]  DELAY_LAST = 8'(START_DELAY - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [7:0]    dly_cnt_reg;
  logic [WL:0]   rd_cnt_reg;
  logic [WL:0]   wr_cnt_reg;
  logic          core_start_reg;
  logic          core_intt_reg;
  logic          wr_active;
  logic          last_write;
  logic [WL-1:0] wr_bitrev;
  logic [WL-1:0] wr_word;

  // Writes are only accepted while a run is streaming or draining, and never past WORDS.
  assign wr_active  = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
  assign wr_en      = wr_active && core_out_valid && (wr_cnt_reg < ALL_WORDS);
  assign last_write = wr_en && (wr_cnt_reg == LAST_WORD);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_DELAY;
      S_DELAY:  if (dly_cnt_reg == DELAY_LAST) state_next = S_STREAM;
      S_STREAM: if (rd_cnt_reg == LAST_WORD) state_next = S_DRAIN;
      S_DRAIN:  if ((wr_cnt_reg == ALL_WORDS) || last_write) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      dly_cnt_reg    <= '0;
      rd_cnt_reg     <= '0;
      wr_cnt_reg     <= '0;
      core_start_reg <= 1'b0;
      core_intt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          dly_cnt_reg <= '0;
          rd_cnt_reg  <= '0;
          wr_cnt_reg  <= '0;
          if (start) core_intt_reg <= intt;
        end
        S_DELAY: begin
          dly_cnt_reg <= dly_cnt_reg + 8'd1;
          if (dly_cnt_reg == DELAY_LAST) core_start_reg <= 1'b1;
        end
        S_STREAM: rd_cnt_reg <= rd_cnt_reg + 1'b1;
        default: ;
      endcase
      if (wr_en) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (state_next == S_DONE) core_start_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < WL; gi++) begin : g_bitrev
    assign wr_bitrev[gi] = wr_cnt_reg[WL-1-gi];
  end

  assign wr_word = (BITREV_WR != 0) ? wr_bitrev : wr_cnt_reg[WL-1:0];

  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    if (state_reg == S_STREAM) rd_addr[WL-1:0] = rd_cnt_reg[WL-1:0];
    wr_addr[WL-1:0] = wr_word;
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign rd_en      = (state_reg == S_STREAM);
  assign core_start = core_start_reg;
  assign core_intt  = core_intt_reg;
  assign core_in    = bram_dout;
  assign bram_din   = core_out;

endmodule

// File: tb/tb_ntt_memory_sequencer.sv
// Directed bench: two WORDS=8 sequencers (linear and bit-reversed write) sharing stimulus,
// plus a 4-lane WORDS=16 sequencer with a zero-latency core.
module tb_ntt_memory_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, intt, valid_ab;
  logic [31:0] bram_dout_ab, core_out_ab;
  logic        busy_a, done_a, rd_en_a, wr_en_a, core_start_a, core_intt_a;
  logic [3:0]  rd_addr_a, wr_addr_a;
  logic [31:0] bram_din_a, core_in_a;
  logic        busy_b, done_b, rd_en_b, wr_en_b, core_start_b, core_intt_b;
  logic [3:0]  rd_addr_b, wr_addr_b;
  logic [31:0] bram_din_b, core_in_b;

  logic        start_c, intt_c, valid_c;
  logic [63:0] bram_dout_c, core_out_c;
  logic        busy_c, done_c, rd_en_c, wr_en_c, core_start_c, core_intt_c;
  logic [4:0]  rd_addr_c, wr_addr_c;
  logic [63:0] bram_din_c, core_in_c;

  ntt_memory_sequencer #(.LOGN(4), .LOGQ(16), .LOG_LANES(1), .START_DELAY(10), .ADDR_W(4), .BITREV_WR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .intt(intt), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .bram_dout(bram_dout_ab), .bram_din(bram_din_a), .core_start(core_start_a),
    .core_intt(core_intt_a), .core_in(core_in_a), .core_out(core_out_ab), .core_out_valid(valid_ab));

  ntt_memory_sequencer #(.LOGN(4), .LOGQ(16), .LOG_LANES(1), .START_DELAY(10), .ADDR_W(4), .BITREV_WR(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .intt(intt), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .bram_dout(bram_dout_ab), .bram_din(bram_din_b), .core_start(core_start_b),
    .core_intt(core_intt_b), .core_in(core_in_b), .core_out(core_out_ab), .core_out_valid(valid_ab));

  ntt_memory_sequencer #(.LOGN(6), .LOGQ(16), .LOG_LANES(2), .START_DELAY(10), .ADDR_W(5), .BITREV_WR(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .intt(intt_c), .busy(busy_c), .done(done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
    .bram_dout(bram_dout_c), .bram_din(bram_din_c), .core_start(core_start_c),
    .core_intt(core_intt_c), .core_in(core_in_c), .core_out(core_out_c), .core_out_valid(valid_c));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nwr    = 0;
  int b0 = -1, b1 = -1;
  bit mi0 = 1'b0, mi1 = 1'b0, ci_idle = 1'b0;
  int br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Offset of cycle c inside the run that owns it, or -1 when no run is modelled.
  function automatic int off_of(int c);
    if (b1 >= 0 && c >= b1) return c - b1;
    if (b0 >= 0 && c >= b0) return c - b0;
    return -1;
  endfunction

  // One cycle on dut_a/dut_b; core model has latency 20 so writes land at offsets 31..38.
  task automatic step_ab(input bit st, input bit it, input bit rs, input bit vx);
    int off;
    bit e_rd, e_wr, e_busy, e_done, e_cs, e_ci;
    off          = off_of(cyc);
    start        = st;
    intt         = it;
    rst          = rs;
    valid_ab     = (off >= 31 && off <= 38) || vx;
    core_out_ab  = $urandom();
    bram_dout_ab = $urandom();
    #1;
    e_busy = (off >= 1 && off <= 39);
    e_rd   = (off >= 11 && off <= 18);
    e_wr   = (off >= 31 && off <= 38);
    e_cs   = (off >= 11 && off <= 38);
    e_done = (off == 39);
    e_ci   = (b1 >= 0 && cyc > b1) ? mi1 : ((b0 >= 0 && cyc > b0) ? mi0 : ci_idle);
    check("busy_a", busy_a, e_busy);
    check("done_a", done_a, e_done);
    check("rd_en_a", rd_en_a, e_rd);
    check("rd_addr_a", rd_addr_a, e_rd ? off - 11 : 0);
    check("wr_en_a", wr_en_a, e_wr);
    if (e_wr) check("wr_addr_a", wr_addr_a, off - 31);
    if (off < 0) check("wr_addr_rst_a", wr_addr_a, 0);
    check("core_start_a", core_start_a, e_cs);
    check("core_intt_a", core_intt_a, e_ci);
    check("bram_din_a", bram_din_a, core_out_ab);
    check("core_in_a", core_in_a, bram_dout_ab);
    check("wr_en_b", wr_en_b, e_wr);
    if (e_wr) check("wr_addr_b", wr_addr_b, br_tab[off - 31]);
    check("done_b", done_b, e_done);
    check("rd_addr_b", rd_addr_b, e_rd ? off - 11 : 0);
    if (wr_en_a) nwr++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int nrd_c, nwr_c;
    rst = 1'b1; start = 1'b0; intt = 1'b0; valid_ab = 1'b0;
    bram_dout_ab = '0; core_out_ab = '0;
    start_c = 1'b0; intt_c = 1'b0; valid_c = 1'b0; bram_dout_c = '0; core_out_c = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, then one idle cycle.
    cyc = 0;
    check("rst_busy_c", busy_c, 0);
    check("rst_done_c", done_c, 0);
    check("rst_rd_en_c", rd_en_c, 0);
    check("rst_wr_en_c", wr_en_c, 0);
    check("rst_core_start_c", core_start_c, 0);
    check("rst_rd_addr_c", rd_addr_c, 0);
    step_ab(0, 0, 0, 0);

    // Single pulse, stray starts in DELAY/DRAIN, mid-run intt change, surplus valids.
    cyc = 0; b0 = 0; mi0 = 0; b1 = -1; nwr = 0;
    for (int c = 0; c < 46; c++)
      step_ab(c == 0 || c == 5 || c == 25, c >= 5, 0, c >= 39 && c <= 41);
    check("t1_wr_count", nwr, 8);

    // start held high: back-to-back runs with intt 0 then 1.
    cyc = 0; b0 = 0; mi0 = 0; b1 = 40; mi1 = 1; nwr = 0;
    for (int c = 0; c < 86; c++)
      step_ab(c <= 40, c >= 1, 0, 0);
    check("t2_wr_count", nwr, 16);

    // Reset on the 4th read, then a fresh clean run.
    cyc = 0; b0 = 0; mi0 = 1; b1 = -1; ci_idle = 1; nwr = 0;
    for (int c = 0; c < 62; c++) begin
      if (c == 15) begin b0 = -1; ci_idle = 0; end
      if (c == 16) begin b0 = 16; mi0 = 1; end
      step_ab(c == 0 || c == 16, 1, c == 14, 0);
    end
    check("t3_wr_count", nwr, 8);

    // Four lanes, WORDS=16, zero-latency core.
    nrd_c = 0; nwr_c = 0;
    for (int c = 0; c < 34; c++) begin
      cyc         = c;
      start_c     = (c == 0);
      valid_c     = (c >= 11 && c <= 26);
      core_out_c  = {$urandom(), $urandom()};
      bram_dout_c = {$urandom(), $urandom()};
      #1;
      check("t4_rd_en", rd_en_c, c >= 11 && c <= 26);
      check("t4_rd_addr", rd_addr_c, (c >= 11 && c <= 26) ? c - 11 : 0);
      check("t4_wr_en", wr_en_c, c >= 11 && c <= 26);
      if (c >= 11 && c <= 26) check("t4_wr_addr", wr_addr_c, c - 11);
      check("t4_done", done_c, c == 28);
      check("t4_busy", busy_c, c >= 1 && c <= 28);
      check("t4_core_start", core_start_c, c >= 11 && c <= 27);
      check("t4_core_in", core_in_c, bram_dout_c);
      check("t4_bram_din", bram_din_c, core_out_c);
      if (rd_en_c) nrd_c++;
      if (wr_en_c) nwr_c++;
      @(posedge clk);
      #1;
    end
    check("t4_rd_count", nrd_c, 16);
    check("t4_wr_count", nwr_c, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_memory_sequencer.md
# ntt_memory_sequencer

Parametrised memory-side sequencer for the streaming NTT/INTT pipeline. It sits between the coefficient BRAMs and an external NTT core. On each `start` it streams one polynomial out of BRAM as `2^LOG_LANES` coefficients per cycle, forwards core results back to BRAM with optional bit-reversed write addressing, and signals completion. It is re-armable: runs may be issued back to back without reset.

## Interface
Parameters:
- `LOGN`, 12: log2 of polynomial length N.
- `LOGQ`, 64: coefficient width in bits.
- `LOG_LANES`, 1: log2 of coefficients per BRAM word; legal range 0..3.
- `START_DELAY`, 10: cycles from accepted `start` to first read; legal range 1..255.
- `ADDR_W`, 11: BRAM address width; must be ≥ `WL`.
- `BITREV_WR`, 0: 1 = write address is bit-reversed over `WL` bits.
- Derived: `WL = LOGN-LOG_LANES`; `WORDS = 2^WL`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: run request; honoured only in IDLE.
- `intt`, in, 1: mode; sampled with an accepted `start`.
- `busy`, out, 1: high from the cycle after acceptance through DONE.
- `done`, out, 1: one-cycle pulse in DONE.
- `rd_en`, out, 1: BRAM read enable.
- `rd_addr`, out, `ADDR_W`: read word address.
- `wr_en`, out, 1: BRAM write enable.
- `wr_addr`, out, `ADDR_W`: write word address.
- `bram_dout`, in, `LOGQ<<LOG_LANES`: BRAM read data; lane k is bits [k*LOGQ +: LOGQ].
- `bram_din`, out, `LOGQ<<LOG_LANES`: write data; equals `core_out`.
- `core_start`, out, 1: level; held high for the whole core run.
- `core_intt`, out, 1: latched mode.
- `core_in`, out, `LOGQ<<LOG_LANES`: equals `bram_dout`.
- `core_out`, in, `LOGQ<<LOG_LANES`: core result data.
- `core_out_valid`, in, 1: `core_out` is valid this cycle.

## Operation
- FSM states: IDLE, DELAY, STREAM, DRAIN, DONE.
- **IDLE**
  - `start=1` → DELAY.
  - Latch `intt` into `core_intt`.
  - Clear the delay counter, `rd_cnt` and `wr_cnt`.
- **DELAY**
  - Count `START_DELAY` cycles, then → STREAM.
- **STREAM**
  - `rd_en=1`; `rd_addr=rd_cnt`, zero-extended; `rd_cnt` increments each cycle.
  - After the read with `rd_cnt=WORDS-1` → DRAIN.
- **DRAIN**
  - `rd_en=0`.
  - Stay until `wr_cnt==WORDS`, then → DONE.
- **Write path** (active in STREAM and DRAIN)
  - `wr_en = core_out_valid && wr_cnt<WORDS`.
  - `wr_addr` = `wr_cnt`, or `bitrev_WL(wr_cnt)` when `BITREV_WR=1`, zero-extended.
  - `wr_cnt` increments on every `wr_en`.
- **Ignored inputs**
  - `core_out_valid` is ignored in IDLE, DELAY and DONE.
  - Surplus valids after `WORDS` writes are ignored.
- **DONE**
  - `done=1` for one cycle; `core_start` drops; → IDLE.
- **Control flags**
  - `core_start` is registered: high on the first STREAM cycle, low on entry to DONE.
  - `busy` is high in DELAY, STREAM, DRAIN and DONE.
- **Start handling**
  - `start` is ignored outside IDLE.
  - A `start` held high through DONE is accepted in the following IDLE cycle, giving back-to-back runs.
  - `intt` changes mid-run have no effect.
- **Counters**
  - `rd_cnt` and `wr_cnt` are `WL+1` bits wide, with no wrap.
  - `WORDS-1` is the last read address.
- **Reset**
  - `rst` in any state → IDLE next cycle, with all counters cleared.
  - Reset values: `busy=done=rd_en=wr_en=core_start=core_intt=0`; `rd_addr=wr_addr=0`.
  - A partially written polynomial is abandoned.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: DELAY; `busy=1`.
- First STREAM cycle: `1+START_DELAY`.
  - In that cycle: `rd_en=1`, `rd_addr=0`, `core_start=1`.
- Last read: cycle `START_DELAY+WORDS`.
- `bram_din`, `core_in`, `wr_en` and `wr_addr` are combinational from inputs and state; there are no added stages.
- Write and read may coincide in STREAM.
- DONE: the cycle after the write with `wr_cnt=WORDS-1`.
  - If that write lands in STREAM, DONE is still deferred until the reads complete: DRAIN is entered and exits immediately.
- Minimum run: `START_DELAY+WORDS+2` cycles from `start` to `done`.

## Test plan
- LOGN=4, LOG_LANES=1, START_DELAY=10 (WORDS=8); pulse `start` at cycle 0 with a core model of latency 20 → `rd_addr` 0..7 on cycles 11..18; 8 writes to addresses 0..7; `done` pulses exactly once; `busy` falls with it.
- Same setup with BITREV_WR=1 → write address sequence 0,4,2,6,1,5,3,7.
- Hold `start=1` continuously → two runs with IDLE gaps of exactly one cycle; `core_intt` follows the `intt` value sampled at each acceptance (0 then 1).
- `start` pulses during DELAY and DRAIN, plus 3 surplus `core_out_valid` after the 8th write → no restart, exactly 8 `wr_en`.
- Assert `rst` for one cycle at the 4th read → next cycle all outputs at reset values; a fresh `start` gives a full clean run from `rd_addr=0`.
- LOG_LANES=2, LOGN=6 (WORDS=16), core latency 0 (valid coincides with each read) → 16 reads and 16 writes; `done` two cycles after the last read; lane data passes bit-exact.
